// File: rtl/count_seq_ctrl_if.sv
// Command/status bundle between a run controller and whatever drives it.
//   master : issues start/stop/pause plus run configuration, observes status
//   slave  : the controller; consumes commands, drives busy/tick/done/Count/
//            CountBar/periods
interface count_seq_ctrl_if #(
    parameter int WIDTH = 3,
    parameter int RPT_W = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             mode;
    logic [WIDTH-1:0] term;
    logic [RPT_W-1:0] repeat_n;
    logic             busy;
    logic             tick;
    logic             done;
    logic [WIDTH-1:0] Count;
    logic [WIDTH-1:0] CountBar;
    logic [RPT_W-1:0] periods;

    modport master (
        output start, stop, pause, mode, term, repeat_n,
        input  busy, tick, done, Count, CountBar, periods
    );

    modport slave (
        input  start, stop, pause, mode, term, repeat_n,
        output busy, tick, done, Count, CountBar, periods
    );
endinterface

// File: rtl/count_seq_ctrl.sv
// Run controller for a WIDTH-bit up-counter. Counts 0..term per period, emits a
// tick at each period end and a done pulse when a run finishes normally.
// One-shot (mode=0) or periodic (mode=1, repeat_n periods, 0 = endless).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low
//   bus   : count_seq_ctrl_if.slave -- start/stop/pause/mode/term/repeat_n in,
//           busy/tick/done/Count/CountBar/periods out (all registered)
module count_seq_ctrl #(
    parameter int WIDTH = 3,
    parameter int RPT_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    count_seq_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [RPT_W-1:0] periods_q, periods_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             mode_q, mode_d;
    logic [RPT_W-1:0] rep_q, rep_d;
    logic             busy_q, busy_d;
    logic             tick_q, tick_d;
    logic             done_q, done_d;
    logic [RPT_W-1:0] periods_inc;

    assign periods_inc = periods_q + RPT_W'(1);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        periods_d = periods_q;
        term_d    = term_q;
        mode_d    = mode_q;
        rep_d     = rep_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    term_d    = bus.term;
                    mode_d    = bus.mode;
                    rep_d     = bus.repeat_n;
                    count_d   = '0;
                    periods_d = '0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (bus.pause) begin
                    state_d = S_HOLD;
                end else if (count_q == term_q) begin
                    count_d   = '0;
                    tick_d    = 1'b1;
                    periods_d = periods_inc;
                    // Compare against the incremented value so the final
                    // period's tick and done land in the same cycle.
                    if (!mode_q || (rep_q != '0 && periods_inc == rep_q)) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            S_HOLD: begin
                if (bus.stop) begin
                    count_d = '0;
                    state_d = S_IDLE;
                end else if (!bus.pause) begin
                    // Exit edge only re-enters RUN; counting resumes next edge.
                    state_d = S_RUN;
                end
            end
            default: begin
                // DONE is a single cycle; start here is dropped, not queued.
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            periods_q <= '0;
            term_q    <= '0;
            mode_q    <= 1'b0;
            rep_q     <= '0;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            periods_q <= periods_d;
            term_q    <= term_d;
            mode_q    <= mode_d;
            rep_q     <= rep_d;
            busy_q    <= busy_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.tick     = tick_q;
    assign bus.done     = done_q;
    assign bus.Count    = count_q;
    assign bus.CountBar = ~count_q;
    assign bus.periods  = periods_q;
endmodule
